// File: rtl/pfb_ctrl_pkg.sv
// rtl/pfb_ctrl_pkg.sv - shared constants and helpers for the PFB tap sequencer
package pfb_ctrl_pkg;

  localparam int MAX_FFT_LOG2 = 11;
  localparam int MIN_FFT_LOG2 = 3;

  function automatic logic [3:0] clamp_fft_log2(input logic [3:0] v);
    if (v < 4'(MIN_FFT_LOG2)) return 4'(MIN_FFT_LOG2);
    if (v > 4'(MAX_FFT_LOG2)) return 4'(MAX_FFT_LOG2);
    return v;
  endfunction

  // True when ph is the final phase of a 2^nfft_log2 frame.
  function automatic logic ph_last(input logic [MAX_FFT_LOG2-1:0] ph,
                                   input logic [3:0]              nfft_log2);
    logic [MAX_FFT_LOG2:0] span;
    span = {{MAX_FFT_LOG2{1'b0}}, 1'b1} << nfft_log2;
    return ({1'b0, ph} == (span - {{MAX_FFT_LOG2{1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/pfb_vld_dly.sv
// rtl/pfb_vld_dly.sv - ce-gated delay line carrying {valid, phase, last} alongside the DSP cascade
module pfb_vld_dly #(
  parameter int LAT = 12,
  parameter int W   = 13
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ce_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [LAT-1:0][W-1:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (ce_i) begin
      sr_q <= {sr_q[LAT-2:0], din_i};
    end
  end

  assign dout_o = sr_q[LAT-1];

endmodule

// File: rtl/pfb_tap_sequencer.sv
// rtl/pfb_tap_sequencer.sv - phase/strobe sequencer and output tracker for the PFB tap cascade
module pfb_tap_sequencer
  import pfb_ctrl_pkg::*;
#(
  parameter int LAT = 12
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              cfg_fft_log2,
  input  logic                    cfg_valid,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [MAX_FFT_LOG2-1:0] phase_addr,
  output logic                    hist_we,
  output logic                    dsp_ce,
  input  logic [15:0]             dsp_p_i,
  input  logic [15:0]             dsp_p_q,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [31:0]             m_tdata,
  output logic [MAX_FFT_LOG2-1:0] m_tuser,
  output logic                    m_tlast,
  output logic [3:0]              nfft_log2
);

  localparam int PW = MAX_FFT_LOG2;
  localparam int DW = PW + 2;

  logic          run_q;
  logic [PW-1:0] ph_q, ph_d;
  logic [3:0]    nfft_q, nfft_d;
  logic [3:0]    pend_val_q, pend_val_d;
  logic          pend_vld_q, pend_vld_d;
  logic          ce, acc, last_ph, apply;
  logic [DW-1:0] dly_in, dly_out;

  // A held output stalls every DSP stage, the tracker and the input together.
  assign ce       = !(m_tvalid && !m_tready);
  assign dsp_ce   = ce;
  assign s_tready = run_q && ce;
  assign acc      = s_tvalid && s_tready;
  assign last_ph  = ph_last(ph_q, nfft_q);
  assign apply    = pend_vld_q && ((ph_q == '0) || (acc && last_ph));

  always_comb begin
    ph_d       = ph_q;
    nfft_d     = nfft_q;
    pend_val_d = pend_val_q;
    pend_vld_d = pend_vld_q;
    if (acc) begin
      ph_d = last_ph ? '0 : ph_q + PW'(1);
    end
    if (apply) begin
      nfft_d     = pend_val_q;
      pend_vld_d = 1'b0;
    end
    if (cfg_valid) begin
      pend_val_d = clamp_fft_log2(cfg_fft_log2);
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      ph_q       <= '0;
      nfft_q     <= 4'(MAX_FFT_LOG2);
      pend_val_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      ph_q       <= ph_d;
      nfft_q     <= nfft_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign dly_in = {acc, ph_q, last_ph};

  pfb_vld_dly #(
    .LAT (LAT),
    .W   (DW)
  ) u_vld_dly (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .ce_i   (ce),
    .din_i  (dly_in),
    .dout_o (dly_out)
  );

  assign m_tvalid   = dly_out[DW-1];
  assign m_tuser    = dly_out[DW-2:1];
  assign m_tlast    = dly_out[0];
  assign m_tdata    = {dsp_p_q, dsp_p_i};
  assign phase_addr = ph_q;
  assign hist_we    = acc;
  assign nfft_log2  = nfft_q;

endmodule

// File: tb/tb_pfb_tap_sequencer.sv
// tb/tb_pfb_tap_sequencer.sv - directed self-checking bench for pfb_tap_sequencer
module tb_pfb_tap_sequencer;
  import pfb_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  cfg_fft_log2;
  logic        cfg_valid;
  logic        s_tvalid;
  logic        s_tready;
  logic [10:0] phase_addr;
  logic        hist_we;
  logic        dsp_ce;
  logic [15:0] dsp_p_i;
  logic [15:0] dsp_p_q;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [10:0] m_tuser;
  logic        m_tlast;
  logic [3:0]  nfft_log2;

  pfb_tap_sequencer #(.LAT(12)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_fft_log2 (cfg_fft_log2),
    .cfg_valid    (cfg_valid),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .phase_addr   (phase_addr),
    .hist_we      (hist_we),
    .dsp_ce       (dsp_ce),
    .dsp_p_i      (dsp_p_i),
    .dsp_p_q      (dsp_p_q),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .nfft_log2    (nfft_log2)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int exp_q[$];
  int ph_model   = 0;
  int size_model = 2048;
  int first_acc  = -1;
  int first_vld  = -1;
  int out_cnt    = 0;
  logic [3:0] nfft_model = 4'd11;
  logic [3:0] nfft_next  = 4'd11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, return just after the next rising edge.
  task automatic cyc();
    int  e;
    bit  lst;
    @(negedge clk);
    cyc_n++;
    chk("nfft_log2", {28'd0, nfft_log2}, {28'd0, nfft_model});
    if (m_tvalid && m_tready) begin
      if (first_vld < 0) first_vld = cyc_n;
      if (exp_q.size() == 0) begin
        chk("spurious_out", {31'd0, m_tvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("m_tuser", {21'd0, m_tuser}, e % 4096);
        chk("m_tlast", {31'd0, m_tlast}, e / 4096);
        out_cnt++;
      end
    end
    if (s_tvalid && s_tready) begin
      if (first_acc < 0) first_acc = cyc_n;
      chk("phase_addr", {21'd0, phase_addr}, ph_model);
      chk("hist_we", {31'd0, hist_we}, 32'd1);
      lst = (ph_model == size_model - 1);
      exp_q.push_back(ph_model + (lst ? 4096 : 0));
      if (lst) begin
        ph_model   = 0;
        nfft_model = nfft_next;
        size_model = 1 << nfft_next;
      end else begin
        ph_model++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_fft_log2 = 4'd0;
    s_tvalid = 1'b1; m_tready = 1'b1; dsp_p_i = 16'd0; dsp_p_q = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready",   {31'd0, s_tready},   32'd0);
    chk("rst_hist_we",    {31'd0, hist_we},    32'd0);
    chk("rst_m_tvalid",   {31'd0, m_tvalid},   32'd0);
    chk("rst_m_tlast",    {31'd0, m_tlast},    32'd0);
    chk("rst_m_tuser",    {21'd0, m_tuser},    32'd0);
    chk("rst_phase_addr", {21'd0, phase_addr}, 32'd0);
    chk("rst_nfft",       {28'd0, nfft_log2},  32'd11);
    chk("rst_dsp_ce",     {31'd0, dsp_ce},     32'd1);

    // Release; run is still low in the first cycle. Select 8 channels while ph is 0.
    s_tvalid = 1'b0; reset_n = 1'b1;
    cfg_fft_log2 = 4'd3; cfg_valid = 1'b1;
    #1;
    chk("run_gate", {31'd0, s_tready}, 32'd0);
    cyc();
    cfg_valid = 1'b0;
    cyc();
    nfft_model = 4'd3; nfft_next = 4'd3; size_model = 8;

    // Continuous stream, 8 phases.
    s_tvalid = 1'b1; first_acc = -1; first_vld = -1; out_cnt = 0;
    repeat (30) cyc();
    chk("latency", first_vld - first_acc, 32'd12);
    chk("no_gaps", out_cnt, 32'd18);

    // Five-cycle downstream stall; DSP PREG held constant by the bench.
    dsp_p_i = 16'h1234; dsp_p_q = 16'hBEEF; m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_s_tready", {31'd0, s_tready}, 32'd0);
      chk("stall_dsp_ce",   {31'd0, dsp_ce},   32'd0);
      chk("stall_hist_we",  {31'd0, hist_we},  32'd0);
      chk("stall_m_tvalid", {31'd0, m_tvalid}, 32'd1);
      chk("stall_m_tuser",  {21'd0, m_tuser},  exp_q[0] % 4096);
      chk("stall_m_tdata",  m_tdata,           32'hBEEF1234);
      chk("stall_phase",    {21'd0, phase_addr}, ph_model);
      cyc();
    end
    m_tready = 1'b1; dsp_p_i = 16'h1357; dsp_p_q = 16'h2468;
    #1;
    chk("resume_s_tready", {31'd0, s_tready}, 32'd1);
    chk("m_tdata_pass",    m_tdata,           32'h24681357);
    repeat (10) cyc();

    // Switch to 16 phases, strobed at ph 5.
    for (int i = 0; i < 20 && phase_addr != 11'd5; i++) cyc();
    chk("at_ph5", {21'd0, phase_addr}, 32'd5);
    cfg_fft_log2 = 4'd4; cfg_valid = 1'b1; nfft_next = 4'd4;
    cyc();
    cfg_valid = 1'b0;
    repeat (30) cyc();
    chk("nfft_16", {28'd0, nfft_log2}, 32'd4);

    // Back-to-back strobes inside one frame: only the later one lands.
    for (int i = 0; i < 20 && phase_addr != 11'd3; i++) cyc();
    chk("at_ph3", {21'd0, phase_addr}, 32'd3);
    cfg_fft_log2 = 4'd5; cfg_valid = 1'b1;
    cyc();
    cfg_fft_log2 = 4'd6; nfft_next = 4'd6;
    cyc();
    cfg_valid = 1'b0;
    repeat (80) cyc();
    chk("nfft_64", {28'd0, nfft_log2}, 32'd6);

    // Bubble pattern: drain first, then alternate valid.
    s_tvalid = 1'b0;
    repeat (14) cyc();
    for (int i = 0; i < 28; i++) begin
      s_tvalid = (i < 16) ? ((i % 2) == 0) : 1'b0;
      #1;
      if (i >= 12) chk("bubble_vld", {31'd0, m_tvalid}, ((i - 12) % 2 == 0) ? 32'd1 : 32'd0);
      cyc();
    end

    // Reset with six samples still in flight.
    s_tvalid = 1'b1;
    repeat (20) cyc();
    s_tvalid = 1'b0;
    repeat (6) cyc();
    chk("pre_rst_vld", {31'd0, m_tvalid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_vld",    {31'd0, m_tvalid}, 32'd0);
    chk("rst_async_tready", {31'd0, s_tready}, 32'd0);
    exp_q.delete();
    ph_model = 0; nfft_model = 4'd11; nfft_next = 4'd11; size_model = 2048;
    repeat (2) cyc();
    reset_n = 1'b1;
    #1;
    chk("rel_phase_addr", {21'd0, phase_addr}, 32'd0);
    repeat (20) cyc();

    // Clamping while idle at ph 0.
    cfg_fft_log2 = 4'd2; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    nfft_model = 4'd3; nfft_next = 4'd3; size_model = 8;
    cyc();
    cfg_fft_log2 = 4'd15; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    nfft_model = 4'd11; nfft_next = 4'd11; size_model = 2048;
    cyc();
    chk("clamp_hi", {28'd0, nfft_log2}, 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
